// File: rtl/sigmoid_bwd_seq.sv
// sigmoid_bwd_seq: backward pass of the sigmoid activation, dx = g * y * (1 - y).
// Three-stage pipeline per lane, one vector per enabled cycle, i_en stalls everything.
// Optional build macro: SIGMOID_BWD_ROUND_EN selects round-half-up in the last
// stage instead of floor (arithmetic shift). Latency and ports are unchanged.

// One lane of the derivative pipeline.
module sigmoid_bwd_lane #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         vld_i,
  input  logic [W-1:0] g_i,
  input  logic [W-1:0] y_i,
  output logic         vld_o,
  output logic [W-1:0] dx_o
);
  localparam int STAGES = 3;

  logic [STAGES:1]       vld_pipe;
  logic [W:0]            ym;
  logic [2*W-1:0]        d_d, d_q;
  logic [W-1:0]          g1_q;
  logic signed [3*W:0]   p_d, p_q;
  logic [3*W+1:0]        sum;
  logic [W-1:0]          dx_d, dx_q;
  logic                  unused_bits;

  // S1: d = y * (2^W - y); the true value peaks at 2^(2W-2), so 2W bits suffice.
  assign ym  = {1'b1, {W{1'b0}}} - {1'b0, y_i};
  assign d_d = {{W{1'b0}}, y_i} * {{(W-1){1'b0}}, ym};

  // S2: signed g times non-negative d; |p| < 2^(3W-1), so 3W+1 bits cannot wrap.
  assign p_d = $signed({{(2*W+1){g1_q[W-1]}}, g1_q}) * $signed({{(W+1){1'b0}}, d_q});

  // S3: drop the 2W fraction bits of y*(1-y); optional half-LSB bias first.
`ifdef SIGMOID_BWD_ROUND_EN
  localparam logic [3*W+1:0] RND = {{(W+2){1'b0}}, 1'b1, {(2*W-1){1'b0}}};
  assign sum = {p_q[3*W], p_q} + RND;
`else
  assign sum = {p_q[3*W], p_q};
`endif
  // |dx| <= |g|/4, so the kept slice already holds the full signed result.
  assign dx_d        = vld_pipe[2] ? sum[3*W-1:2*W] : '0;
  assign unused_bits = ^{sum[3*W+1:3*W], sum[2*W-1:0]};

  // Stage registers: reset clears, i_en low freezes data and valid together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      d_q      <= '0;
      g1_q     <= '0;
      p_q      <= '0;
      dx_q     <= '0;
    end else if (en_i) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], vld_i};
      d_q      <= d_d;
      g1_q     <= g_i;
      p_q      <= p_d;
      dx_q     <= dx_d;
    end
  end

  assign vld_o = vld_pipe[STAGES];
  assign dx_o  = dx_q;
endmodule

// Top: NUM_DATA independent lanes sharing clock, reset and enable.
module sigmoid_bwd_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_DATA   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic [NUM_DATA-1:0]            i_valid,
  input  logic [NUM_DATA*DATA_WIDTH-1:0] i_grad_bus,
  input  logic [NUM_DATA*DATA_WIDTH-1:0] i_act_bus,
  output logic [NUM_DATA-1:0]            o_valid,
  output logic [NUM_DATA*DATA_WIDTH-1:0] o_data_bus
);
  for (genvar l = 0; l < NUM_DATA; l++) begin : g_lane
    sigmoid_bwd_lane #(.W(DATA_WIDTH)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en_i  (i_en),
      .vld_i (i_valid[l]),
      .g_i   (i_grad_bus[l*DATA_WIDTH +: DATA_WIDTH]),
      .y_i   (i_act_bus[l*DATA_WIDTH +: DATA_WIDTH]),
      .vld_o (o_valid[l]),
      .dx_o  (o_data_bus[l*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_sigmoid_bwd_seq.sv
// Bench for sigmoid_bwd_seq, 4 lanes of 8 bits. A queue model of enabled-cycle
// history predicts outputs every cycle; directed vectors add literal expectations.
module tb_sigmoid_bwd_seq;
  localparam int W = 8;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_en = 1'b1;
  logic [N-1:0]     i_valid = '0;
  logic [N*W-1:0]   i_grad_bus = '0;
  logic [N*W-1:0]   i_act_bus = '0;
  logic [N-1:0]     o_valid;
  logic [N*W-1:0]   o_data_bus;

  int errors = 0;
  int checks = 0;

  sigmoid_bwd_seq #(.DATA_WIDTH(W), .NUM_DATA(N)) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid),
    .i_grad_bus(i_grad_bus), .i_act_bus(i_act_bus),
    .o_valid(o_valid), .o_data_bus(o_data_bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // dx = floor or round-half-up of g*y*(2^8-y)/2^16, plain integer arithmetic.
  function automatic logic [7:0] ref_dx(input logic [7:0] y, input logic [7:0] g);
    longint d, p;
    d = longint'(y) * (256 - longint'(y));
    p = longint'($signed(g)) * d;
`ifdef SIGMOID_BWD_ROUND_EN
    p = p + 32768;
`endif
    return 8'(p >>> 16);
  endfunction

  typedef struct { logic [N-1:0] v; logic [N*W-1:0] d; } ent_t;
  ent_t hist[$];

  // Model: each enabled edge records what that edge's inputs must produce.
  always @(posedge clk) begin
    ent_t e;
    if (rst) hist.delete();
    else if (i_en) begin
      for (int l = 0; l < N; l++) begin
        e.v[l] = i_valid[l];
        e.d[l*W +: W] = i_valid[l] ? ref_dx(i_act_bus[l*W +: W], i_grad_bus[l*W +: W]) : 8'h00;
      end
      hist.push_back(e);
      if (hist.size() > 3) void'(hist.pop_front());
    end
  end

  // Compare: output equals the entry recorded 3 enabled edges ago, zero before that.
  always begin
    logic [N-1:0]   ev;
    logic [N*W-1:0] ed;
    @(posedge clk);
    #1;
    ev = '0; ed = '0;
    if (!rst && hist.size() == 3) begin ev = hist[0].v; ed = hist[0].d; end
    chk("o_valid", 32'(o_valid), 32'(ev));
    chk("o_data", o_data_bus, ed);
  end

  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] y, input logic [N*W-1:0] g);
    @(negedge clk);
    i_valid = v; i_act_bus = y; i_grad_bus = g;
  endtask

  task automatic idle();
    drive('0, '0, '0);
  endtask

  // One vector on lane 0, then idle; check the literal after 3 edges.
  task automatic directed(input string name, input logic [7:0] y, input logic [7:0] g,
                          input logic [7:0] exp);
    chk({name, "_model"}, 32'(ref_dx(y, g)), 32'(exp));
    drive(4'b0001, 32'(y), 32'(g));
    idle();
    repeat (2) @(negedge clk);
    chk({name, "_vld"}, 32'(o_valid[0]), 32'd1);
    chk(name, 32'(o_data_bus[7:0]), 32'(exp));
  endtask

  initial begin
    // Reset with random traffic on the inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_valid = 4'($urandom); i_act_bus = $urandom; i_grad_bus = $urandom;
      chk("rst_vld", 32'(o_valid), 32'd0);
      chk("rst_data", o_data_bus, 32'd0);
    end
    idle();
    rst = 1'b0;
    idle();

    // Peak and boundary values with first-beat latency.
`ifdef SIGMOID_BWD_ROUND_EN
    directed("peak_pos", 8'd128, 8'd127, 8'd32);
    directed("half_neg", 8'd128, 8'hFF, 8'd0);
`else
    directed("peak_pos", 8'd128, 8'd127, 8'd31);
    directed("half_neg", 8'd128, 8'hFF, 8'hFF);
`endif
    directed("peak_neg", 8'd128, 8'h80, 8'hE0);
    directed("y_zero", 8'd0, 8'd127, 8'd0);
    directed("y_max", 8'd255, 8'd127, 8'd0);

    // Stall mid-stream: model checks hold and ordering every cycle.
    drive(4'b0001, 32'd50, 32'd100);
    drive(4'b0001, 32'd100, 32'hB0);
    @(negedge clk); i_en = 1'b0;
    @(negedge clk);
    @(negedge clk); i_en = 1'b1; i_act_bus = 32'd200; i_grad_bus = 32'd77;
    drive(4'b0001, 32'd30, 32'hC8);
    idle();
    repeat (5) @(negedge clk);

    // Reset with two vectors in flight: they must never appear.
    drive(4'b0001, 32'd128, 32'd127);
    drive(4'b0001, 32'd64, 32'd100);
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    chk("midrst_vld", 32'(o_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Lanes 0 and 2 valid, 1 and 3 carry data but no valid.
    drive(4'b0101, {8'd128, 8'd200, 8'd10, 8'd64}, {8'd127, 8'hCE, 8'd5, 8'd100});
    idle();
    repeat (2) @(negedge clk);
    chk("lanes_vld", 32'(o_valid), 32'b0101);
`ifdef SIGMOID_BWD_ROUND_EN
    chk("lane0", 32'(o_data_bus[7:0]), 32'd19);
`else
    chk("lane0", 32'(o_data_bus[7:0]), 32'd18);
`endif
    chk("lane2", 32'(o_data_bus[23:16]), 32'hF7);
    chk("lane13", 32'({o_data_bus[31:24], o_data_bus[15:8]}), 32'd0);

    // Exhaustive (y,g) sweep on lane 0, streaming back to back.
    for (int i = 0; i < 65536; i++) drive(4'b0001, 32'(i[7:0]), 32'(i[15:8]));
    idle();
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
